// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM peripheral:
// register addresses, CTRL bit positions, clamp and slew arithmetic.
package servo_pkg;

  // Word addresses of the Avalon register map
  typedef enum logic [1:0] {
    ADDR_CTRL    = 2'd0,
    ADDR_TARGET  = 2'd1,
    ADDR_STEP    = 2'd2,
    ADDR_CURRENT = 2'd3
  } reg_addr_e;

  // Bit positions inside the CTRL word
  localparam int EN_BIT   = 0;
  localparam int SLEW_BIT = 1;
  localparam int BUSY_BIT = 8;

  // Width of the STEP field
  localparam int STEP_W = 16;

  // Clamp a full 32-bit write value into [lo, hi]; all 32 bits take part so
  // huge values saturate at hi instead of wrapping into the legal range.
  function automatic logic [31:0] clamp_pulse(input logic [31:0] value,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] res;
    if (value < lo) begin
      res = lo;
    end else if (value > hi) begin
      res = hi;
    end else begin
      res = value;
    end
    return res;
  endfunction

  // Next pulse width at a period boundary: jump straight to the target when
  // slewing is off or the step is zero, otherwise move by at most one step
  // without overshooting the target.
  function automatic logic [31:0] slew_next(input logic [31:0] cur,
                                            input logic [31:0] target,
                                            input logic [31:0] step,
                                            input logic        slew_en);
    logic [31:0] res;
    if (!slew_en || (step == 32'd0)) begin
      res = target;
    end else if (target > cur) begin
      res = ((target - cur) <= step) ? target : (cur + step);
    end else begin
      res = ((cur - target) <= step) ? target : (cur - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_avalon_if.sv
// Avalon-MM slave bus bundle for the servo PWM register file.
interface servo_pwm_avalon_if;

  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  // Interconnect / bus-functional-model side
  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  // Peripheral side
  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );

endinterface

// File: rtl/servo_pwm_core.sv
// Period counter, pulse-width register updated only at the period wrap,
// and the registered compare that drives the servo pin.
module servo_pwm_core
  import servo_pkg::*;
#(
  parameter int PERIOD      = 1000000,
  parameter int CNT_W       = 21,
  parameter int RESET_PULSE = 75000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              slew_en,
  input  logic [STEP_W-1:0] step,
  input  logic [CNT_W-1:0]  target,
  output logic [CNT_W-1:0]  cur,
  output logic              servo_out
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CUR_RESET = CNT_W'(RESET_PULSE);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cur_reg;
  logic [CNT_W-1:0] cur_next;
  logic             servo_reg;
  logic             servo_next;
  logic             wrap;

  // Last cycle of an active period: the only point where cur may change
  assign wrap = enable && (cnt_reg == LAST_CNT);

  // Counter runs 0..PERIOD-1 while enabled and parks at 0 while disabled
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (!enable || wrap) begin
      cnt_next = '0;
    end
  end

  // Pulse width follows the target (optionally slew-limited) at the wrap only
  always_comb begin
    cur_next = cur_reg;
    if (wrap) begin
      cur_next = CNT_W'(slew_next(32'(cur_reg), 32'(target), 32'(step), slew_en));
    end
  end

  // Output is high for the first cur counts of each period; a cleared enable
  // drops it immediately regardless of where the counter is
  always_comb begin
    servo_next = enable && (cnt_reg < cur_reg);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      cur_reg   <= CUR_RESET;
      servo_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      cur_reg   <= cur_next;
      servo_reg <= servo_next;
    end
  end

  assign cur       = cur_reg;
  assign servo_out = servo_reg;

endmodule

// File: rtl/servo_pwm_avalon.sv
// Avalon-MM servo PWM peripheral: register file with clamped TARGET writes,
// registered single-cycle reads, and the PWM core for one channel.
// Legal configuration: MIN_PULSE <= MAX_PULSE < PERIOD and 2^CNT_W > PERIOD.
module servo_pwm_avalon
  import servo_pkg::*;
#(
  parameter int PERIOD    = 1000000,
  parameter int MIN_PULSE = 50000,
  parameter int MAX_PULSE = 100000,
  parameter int CNT_W     = 21
) (
  input  logic               clk,
  input  logic               reset_n,
  servo_pwm_avalon_if.slave  avs,
  output logic               servo_out
);

  localparam int               RESET_PULSE  = (MIN_PULSE + MAX_PULSE) / 2;
  localparam logic [31:0]      MIN_PULSE_32 = 32'(MIN_PULSE);
  localparam logic [31:0]      MAX_PULSE_32 = 32'(MAX_PULSE);
  localparam logic [CNT_W-1:0] TARGET_RESET = CNT_W'(RESET_PULSE);

  logic              enable_reg;
  logic              slew_en_reg;
  logic [STEP_W-1:0] step_reg;
  logic [CNT_W-1:0]  target_reg;
  logic [CNT_W-1:0]  target_next;
  logic [31:0]       readdata_reg;
  logic [31:0]       read_word;
  logic [CNT_W-1:0]  cur;
  logic              busy;
  reg_addr_e         addr;

  assign addr = reg_addr_e'(avs.avs_address);

  // Clamp happens on the write path so TARGET always holds a legal width
  assign target_next = CNT_W'(clamp_pulse(avs.avs_writedata, MIN_PULSE_32, MAX_PULSE_32));

  // Busy while the pulse width is still travelling toward the target
  assign busy = (cur != target_reg);

  // Register file writes; CURRENT is read-only so writes to it fall through
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_reg  <= 1'b0;
      slew_en_reg <= 1'b0;
      step_reg    <= '0;
      target_reg  <= TARGET_RESET;
    end else if (avs.avs_write) begin
      case (addr)
        ADDR_CTRL: begin
          enable_reg  <= avs.avs_writedata[EN_BIT];
          slew_en_reg <= avs.avs_writedata[SLEW_BIT];
        end
        ADDR_TARGET: target_reg <= target_next;
        ADDR_STEP:   step_reg   <= avs.avs_writedata[STEP_W-1:0];
        default: ;
      endcase
    end
  end

  // Read mux built from the pre-edge register values, so a same-cycle
  // write never leaks into the data returned by a read
  always_comb begin
    read_word = '0;
    case (addr)
      ADDR_CTRL: begin
        read_word[EN_BIT]   = enable_reg;
        read_word[SLEW_BIT] = slew_en_reg;
        read_word[BUSY_BIT] = busy;
      end
      ADDR_TARGET:  read_word = 32'(target_reg);
      ADDR_STEP:    read_word = 32'(step_reg);
      ADDR_CURRENT: read_word = 32'(cur);
      default:      read_word = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else if (avs.avs_read) begin
      readdata_reg <= read_word;
    end
  end

  assign avs.avs_readdata = readdata_reg;

  servo_pwm_core #(
    .PERIOD      (PERIOD),
    .CNT_W       (CNT_W),
    .RESET_PULSE (RESET_PULSE)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable_reg),
    .slew_en   (slew_en_reg),
    .step      (step_reg),
    .target    (target_reg),
    .cur       (cur),
    .servo_out (servo_out)
  );

endmodule

// File: doc/servo_pwm_avalon.md
Name: servo_pwm_avalon

Overview:
- Avalon-MM slave peripheral that generates the servo control signal for one servo channel.
- Sits inside the system interconnect, one instance per channel; servo_out drives the top-level servo_control_N export directly.
- Software writes a target pulse width. The block produces a fixed-period PWM waveform.
- The pulse width is updated only at period boundaries, with optional slew limiting.

Parameters:
- PERIOD, 1000000, PWM period in clk cycles (20 ms at 50 MHz).
- MIN_PULSE, 50000, minimum legal pulse width in cycles (1 ms).
- MAX_PULSE, 100000, maximum legal pulse width in cycles (2 ms); must satisfy MIN_PULSE <= MAX_PULSE < PERIOD.
- CNT_W, 21, counter/pulse register width; must satisfy 2^CNT_W > PERIOD.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- avs_address  in  2  word address of register
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid one cycle after avs_read
- servo_out  out  1  PWM output to servo pin

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 enable, bit1 slew_en (R/W). Bit8 busy is read-only and equals (cur != target).
  - 1 TARGET: R/W. A write is clamped to [MIN_PULSE, MAX_PULSE]; the comparison uses all 32 bits. Reads return the clamped value.
  - 2 STEP: bits[15:0] R/W, slew step in cycles per period.
  - 3 CURRENT: read-only pulse width currently in effect, zero-extended. Writes are ignored.
- Reset (reset_n low at a clk edge):
  - enable = 0, slew_en = 0, STEP = 0.
  - target = cur = (MIN_PULSE+MAX_PULSE)/2.
  - cnt = 0, servo_out = 0, avs_readdata = 0.
- Bus timing:
  - No waitrequest.
  - Writes take effect at the clk edge where avs_write is high.
  - Reads are registered, one-cycle latency.
  - Simultaneous read and write to the same address returns the old value.
  - avs_readdata holds its last value when avs_read is low.
- Period counter:
  - While enable = 1, cnt counts 0..PERIOD-1 and wraps to 0.
  - While enable = 0, cnt is held at 0.
- Output:
  - servo_out is registered: servo_out <= enable && (cnt < cur).
  - servo_out lags cnt by one cycle. The high time is exactly cur cycles and the period is exactly PERIOD cycles.
- Enable and disable:
  - Clearing enable forces servo_out low on the next edge, even mid-pulse; cur is retained.
  - Setting enable starts cnt at 0. servo_out rises on the following edge.
- Update point:
  - cur changes only on the edge where cnt == PERIOD-1 and enable = 1, so it never glitches mid-period.
  - If slew_en = 0 or STEP = 0: cur <= target.
  - Otherwise: cur moves toward target by STEP without overshoot. If |target-cur| <= STEP, cur <= target.
  - While disabled, cur does not move.
- TARGET write on the same edge as a wrap: the wrap uses the old target, and the new value applies at the next wrap.
- Reset asserted mid-pulse: servo_out goes low on that edge and all state returns to reset values.

Decomposition:
- Package servo_pkg holds:
  - register address constants (ADDR_CTRL=0, ADDR_TARGET=1, ADDR_STEP=2, ADDR_CURRENT=3)
  - CTRL bit indices (EN_BIT=0, SLEW_BIT=1, BUSY_BIT=8)
  - the clamp and slew-next-value functions
- One sub-module, servo_pwm_core, contains the period counter, the cur register update at wrap, and the registered compare to servo_out.
- The top level holds the Avalon register file and the clamp logic.

Test Plan (bench overrides PERIOD=1000, MIN_PULSE=50, MAX_PULSE=100, CNT_W=10):
- Reset, read CURRENT -> 75. Read CTRL -> 0. servo_out stays 0 for 2000 cycles.
- Write CTRL=1 -> servo_out high for exactly 75 cycles per 1000-cycle period over 3 periods.
- Write TARGET=20 then 500, read back -> 50 then 100. With slew off, the high time changes only after the next wrap.
- slew_en=1, STEP=10, cur=50, TARGET=100 -> successive periods show high times 50,60,70,80,90,100. busy reads 1 until cur=100.
- STEP=30, cur=50, TARGET=95 -> 50,80,95; no overshoot.
- Clear enable at cnt=20 mid-pulse -> servo_out low next cycle. Re-enable -> a full cur-wide pulse starts from cnt=0.
- Assert reset_n=0 mid-pulse -> servo_out 0 on that edge. CURRENT reads 75 after release.
